// File: rtl/instr_loader_pkg.sv
// Shared constants and FSM state type for the instruction loader and its packer.
package instr_loader_pkg;

    localparam logic [1:0]  OP_DP     = 2'b00;
    localparam logic [1:0]  OP_MEM    = 2'b01;
    localparam logic [1:0]  OP_BR     = 2'b10;
    localparam logic [1:0]  OP_ILL    = 2'b11;

    localparam logic [31:0] HALT_WORD = 32'hEAFF_FFFE;
    localparam logic [3:0]  COND_AL   = 4'hE;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        HALT,
        DONE
    } state_t;

endpackage

// File: rtl/instr_loader_if.sv
// Field-level instruction request channel from the boot/self-test sequencer to the loader.
interface instr_loader_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [3:0]  req_cond;
    logic [5:0]  req_funct;
    logic [3:0]  req_rn;
    logic [3:0]  req_rd;
    logic [11:0] req_src2;
    logic [23:0] req_imm24;

    modport master (
        output req_valid, req_op, req_cond, req_funct, req_rn, req_rd, req_src2, req_imm24,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_op, req_cond, req_funct, req_rn, req_rd, req_src2, req_imm24,
        output req_ready
    );
endinterface

// File: rtl/instr_packer.sv
// Combinational field-to-word packer for ARM data-proc, memory and branch encodings.
module instr_packer
    import instr_loader_pkg::*;
(
    input  logic [1:0]  op,
    input  logic [3:0]  cond,
    input  logic [5:0]  funct,
    input  logic [3:0]  rn,
    input  logic [3:0]  rd,
    input  logic [11:0] src2,
    input  logic [23:0] imm24,
    output logic [31:0] word,
    output logic        illegal
);

    always_comb begin
        // Branch keeps only the link bit from funct; everything else packs verbatim.
        if (op == OP_BR) word = {cond, OP_BR, 1'b1, funct[4], imm24};
        else             word = {cond, op, funct, rn, rd, src2};
    end

    assign illegal = (op == OP_ILL);

endmodule

// File: rtl/instr_loader.sv
// Packs field requests into instruction words, writes them to imem and closes each program with a halt.
// Optional build macro: INSTR_LOADER_CHECK_EN (drop op=11 requests and flag err_illegal).
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              load_end,
    instr_loader_if.slave     req,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              done,
    output logic              full,
    output logic              err_illegal
);

    state_t      state, state_n;
    logic        hpend, hpend_n;
    logic        acc, ill, wr_req;
    logic        do_req, do_halt, restart;
    logic [31:0] pk_word;

    instr_packer u_pack (
        .op      (req.req_op),
        .cond    (req.req_cond),
        .funct   (req.req_funct),
        .rn      (req.req_rn),
        .rd      (req.req_rd),
        .src2    (req.req_src2),
        .imm24   (req.req_imm24),
        .word    (pk_word),
        .illegal (ill)
    );

    assign full          = (word_count == (ADDR_W+1)'(DEPTH));
    assign req.req_ready = (state == LOAD) && !full;
    assign done          = (state == DONE);
    assign acc           = req.req_valid && req.req_ready;

`ifdef INSTR_LOADER_CHECK_EN
    assign wr_req = acc && !ill;
`else
    logic unused_ill;
    assign wr_req     = acc;
    assign unused_ill = ill;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            hpend <= 1'b0;
        end else begin
            state <= state_n;
            hpend <= hpend_n;
        end
    end

    always_comb begin
        state_n = state;
        hpend_n = hpend;
        do_req  = 1'b0;
        do_halt = 1'b0;
        restart = 1'b0;
        case (state)
            IDLE: begin
                if (load_start) begin
                    restart = 1'b1;
                    state_n = LOAD;
                end
            end
            LOAD: begin
                if (load_start) begin
                    restart = 1'b1;
                end else begin
                    do_req = wr_req;
                    if (load_end) begin
                        if (full) begin
                            state_n = DONE;
                        end else if (acc) begin
                            // Request word goes out first; halt follows next cycle.
                            state_n = HALT;
                            hpend_n = 1'b1;
                        end else begin
                            do_halt = 1'b1;
                            state_n = HALT;
                            hpend_n = 1'b0;
                        end
                    end
                end
            end
            HALT: begin
                if (load_start) begin
                    restart = 1'b1;
                    state_n = LOAD;
                end else if (hpend && !full) begin
                    do_halt = 1'b1;
                    hpend_n = 1'b0;
                end else begin
                    state_n = DONE;
                end
            end
            DONE: begin
                if (load_start) begin
                    restart = 1'b1;
                    state_n = LOAD;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            imem_we     <= 1'b0;
            imem_addr   <= '0;
            imem_wdata  <= '0;
            word_count  <= '0;
            err_illegal <= 1'b0;
        end else begin
            imem_we <= do_req || do_halt;
            if (do_req || do_halt) begin
                imem_addr  <= word_count[ADDR_W-1:0];
                imem_wdata <= do_req ? pk_word : HALT_WORD;
            end
            if (restart)                word_count <= '0;
            else if (do_req || do_halt) word_count <= word_count + 1'b1;
`ifdef INSTR_LOADER_CHECK_EN
            if (restart)         err_illegal <= 1'b0;
            else if (acc && ill) err_illegal <= 1'b1;
`else
            err_illegal <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: directed cases plus randomized programs against a queue model.
module tb_instr_loader;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [31:0] HALT = 32'hEAFF_FFFE;
`ifdef INSTR_LOADER_CHECK_EN
    localparam bit CHECKEN = 1'b1;
`else
    localparam bit CHECKEN = 1'b0;
`endif

    typedef struct packed {
        logic [1:0]  op;
        logic [3:0]  cond;
        logic [5:0]  funct;
        logic [3:0]  rn;
        logic [3:0]  rd;
        logic [11:0] src2;
        logic [23:0] imm24;
    } req_t;

    typedef struct {
        int          addr;
        logic [31:0] w;
        int          cyc;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset, load_start, load_end;
    logic              imem_we, done, full, err_illegal;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   word_count;

    instr_loader_if rif ();

    instr_loader #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .load_start  (load_start),
        .load_end    (load_end),
        .req         (rif),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .word_count  (word_count),
        .done        (done),
        .full        (full),
        .err_illegal (err_illegal)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   total = 0;
    int   fails = 0;
    exp_t q[$];
    int   m_count;
    bit   m_err;
    int   m_done_cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected word built from the encoding rules with plain shifts.
    function automatic logic [31:0] enc(input req_t r);
        if (r.op == 2'd2)
            return (32'(r.cond) << 28) | 32'h0A00_0000 | (32'(r.funct[4]) << 24) | 32'(r.imm24);
        return (32'(r.cond) << 28) | (32'(r.op) << 26) | (32'(r.funct) << 20) |
               (32'(r.rn) << 16) | (32'(r.rd) << 12) | 32'(r.src2);
    endfunction

    function automatic req_t mk(input logic [1:0] op, input logic [3:0] cond, input logic [5:0] funct,
                                input logic [3:0] rn, input logic [3:0] rd, input logic [11:0] src2,
                                input logic [23:0] imm24);
        req_t r;
        r = '{op, cond, funct, rn, rd, src2, imm24};
        return r;
    endfunction

    // Monitor: every write strobe must match the head of the scoreboard, including its cycle.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_write", {30'd0, imem_addr}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("wr_addr", 32'(imem_addr), 32'(e.addr));
                chk("wr_data", imem_wdata, e.w);
                chk("wr_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // All tasks start and end at a falling edge.
    task automatic drive(input req_t r);
        rif.req_op    = r.op;
        rif.req_cond  = r.cond;
        rif.req_funct = r.funct;
        rif.req_rn    = r.rn;
        rif.req_rd    = r.rd;
        rif.req_src2  = r.src2;
        rif.req_imm24 = r.imm24;
    endtask

    task automatic start();
        rif.req_valid = 1'b0;
        load_end      = 1'b0;
        load_start    = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        m_count    = 0;
        m_err      = 1'b0;
        chk("start_count", 32'(word_count), 32'd0);
        chk("start_ready", 32'(rif.req_ready), 32'd1);
    endtask

    task automatic send(input req_t r, input bit with_end, input logic [31:0] w);
        int n = 0;
        int e;
        drive(r);
        rif.req_valid = 1'b1;
        load_end      = 1'b0;
        while (rif.req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            chk("accept_timeout", 32'(n), 32'd0);
            rif.req_valid = 1'b0;
            return;
        end
        load_end = with_end;
        e = cyc;
        if (CHECKEN && r.op == 2'd3) begin
            m_err = 1'b1;
        end else begin
            q.push_back('{m_count, w, e + 1});
            m_count++;
        end
        if (with_end) begin
            if (m_count < DEPTH) begin
                q.push_back('{m_count, HALT, e + 2});
                m_count++;
                m_done_cyc = e + 3;
            end else begin
                m_done_cyc = e + 2;
            end
        end
        @(negedge clk);
        load_end = 1'b0;
    endtask

    task automatic idle();
        rif.req_valid = 1'b0;
        load_end      = 1'b0;
        @(negedge clk);
    endtask

    task automatic finish_prog();
        rif.req_valid = 1'b0;
        load_end      = 1'b1;
        if (m_count < DEPTH) begin
            q.push_back('{m_count, HALT, cyc + 1});
            m_count++;
            m_done_cyc = cyc + 2;
        end else begin
            m_done_cyc = cyc + 1;
        end
        @(negedge clk);
        load_end = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        rif.req_valid = 1'b0;
        load_end      = 1'b0;
        while (cyc < m_done_cyc - 1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (cyc == m_done_cyc - 1) begin
            chk("done_early", 32'(done), 32'd0);
            @(negedge clk);
        end
        chk("done", 32'(done), 32'd1);
        chk("count", 32'(word_count), 32'(m_count));
        chk("full", 32'(full), 32'(m_count == DEPTH));
        chk("err", 32'(err_illegal), 32'(m_err));
        chk("ready_done", 32'(rif.req_ready), 32'd0);
        @(negedge clk);
        chk("pending", 32'(q.size()), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        req_t r;
        reset = 1'b1;
        load_start = 1'b0;
        load_end = 1'b0;
        rif.req_valid = 1'b0;
        drive('0);
        m_count = 0;
        m_err = 1'b0;
        m_done_cyc = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_count", 32'(word_count), 32'd0);
        chk("rst_flags", {29'd0, done, full, err_illegal}, 32'd0);
        chk("rst_ready", 32'(rif.req_ready), 32'd0);

        // DP word then a separate load_end.
        start();
        send(mk(2'd0, 4'hE, 6'b101000, 4'd2, 4'd1, 12'h005, 24'h0), 1'b0, 32'hE282_1005);
        finish_prog();
        wait_done();

        // Back-to-back memory and branch; load_end rides on the branch.
        start();
        send(mk(2'd1, 4'hE, 6'b011001, 4'd0, 4'd3, 12'h008, 24'h0), 1'b0, 32'hE590_3008);
        send(mk(2'd2, 4'hE, 6'b010000, 4'd0, 4'd0, 12'h000, 24'h000010), 1'b1, 32'hEB00_0010);
        wait_done();

        // Fill to DEPTH with valid held; the extra request must stall.
        start();
        for (int i = 0; i < DEPTH; i++) begin
            r = mk(2'd0, 4'(i), 6'(i * 5), 4'(i), 4'(i + 1), 12'(i * 3), 24'h0);
            send(r, 1'b0, enc(r));
        end
        chk("full_set", 32'(full), 32'd1);
        chk("full_ready", 32'(rif.req_ready), 32'd0);
        rif.req_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stall_ready", 32'(rif.req_ready), 32'd0);
            chk("stall_count", 32'(word_count), 32'(DEPTH));
        end
        finish_prog();
        wait_done();

        // op=11 request: dropped and flagged when checking is built in, packed otherwise.
        start();
        r = mk(2'd3, 4'hE, 6'h2A, 4'd5, 4'd6, 12'h123, 24'h0);
        send(r, 1'b0, enc(r));
        idle();
        chk("ill_err", 32'(err_illegal), 32'(m_err));
        chk("ill_count", 32'(word_count), 32'(m_count));
        start();
        chk("ill_clear", 32'(err_illegal), 32'd0);

        // Reset lands while an accepted word is on the write port.
        r = mk(2'd0, 4'hA, 6'h11, 4'd7, 4'd8, 12'hABC, 24'h0);
        drive(r);
        rif.req_valid = 1'b1;
        q.push_back('{0, enc(r), cyc + 1});
        @(posedge clk);
        #1;
        reset = 1'b1;
        rif.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_we", 32'(imem_we), 32'd0);
        chk("mid_addr_data", imem_wdata | 32'(imem_addr), 32'd0);
        chk("mid_count", 32'(word_count), 32'd0);
        chk("mid_flags", {29'd0, done, full, err_illegal}, 32'd0);
        chk("mid_ready", 32'(rif.req_ready), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_idle_ready", 32'(rif.req_ready), 32'd0);

        // Randomized programs.
        for (int p = 0; p < 16; p++) begin
            int  n;
            bit  ended;
            start();
            n = $urandom_range(0, 5);
            ended = 1'b0;
            for (int i = 0; i < n && m_count < DEPTH; i++) begin
                bit last_end;
                r.op    = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
                r.cond  = 4'($urandom);
                r.funct = 6'($urandom);
                r.rn    = 4'($urandom);
                r.rd    = 4'($urandom);
                r.src2  = 12'($urandom);
                r.imm24 = 24'($urandom);
                if ($urandom_range(0, 3) == 0) idle();
                last_end = (i == n - 1) && ($urandom_range(0, 1) == 1);
                send(r, last_end, enc(r));
                ended = last_end;
            end
            if (!ended) begin
                if ($urandom_range(0, 1) == 1) idle();
                finish_prog();
            end
            wait_done();
        end

        repeat (3) @(negedge clk);
        chk("final_pending", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
